// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the buart receiver and the J1 io_din mux: drains bytes with a one-cycle ack.
// Define UART_RX_FIFO_OVERRUN_EN to ack-and-drop bytes arriving while full and set a sticky overrun flag.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ack,
  input  logic                  rd,
  input  logic                  clr,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  in_ack_q, in_ack_d;
  logic                  push_rq, push, pop, is_full;

  // The ~in_ack term hides buart's stale valid in the cycle after an ack.
  assign push_rq = in_valid & ~in_ack_q;
  assign is_full = (count_q == DEPTH_CNT);
  assign pop     = rd & (count_q != '0) & ~clr;
  assign push    = push_rq & (~is_full | (rd & (count_q != '0))) & ~clr;

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic drop;

  assign drop = push_rq & is_full & ~rd & ~clr;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    in_ack_d = push;
`ifdef UART_RX_FIFO_OVERRUN_EN
    overrun_d = overrun_q;
    if (drop) begin
      in_ack_d  = 1'b1;
      overrun_d = 1'b1;
    end
`endif
    if (push) wptr_d = wptr_q + DEPTH_LOG2'(1);
    if (pop)  rptr_d = rptr_q + DEPTH_LOG2'(1);
    if (push && !pop)      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    else if (pop && !push) count_d = count_q - (DEPTH_LOG2 + 1)'(1);
    // Clear wins over push and pop; in_ack is already 0 because push is masked.
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
`ifdef UART_RX_FIFO_OVERRUN_EN
      overrun_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!resetq) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      in_ack_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      in_ack_q <= in_ack_d;
    end
  end

`ifdef UART_RX_FIFO_OVERRUN_EN
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) overrun_q <= 1'b0;
    else         overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  // NOTE: the storage array is deliberately not reset; out_data is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= in_data;
  end

  assign in_ack    = in_ack_q;
  assign count     = count_q;
  assign full      = is_full;
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rptr_q] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; the bench plays the buart side of the handshake.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       resetq;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ack;
  logic       rd;
  logic       clr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       full;
  logic [4:0] count;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk       (clk),
    .resetq    (resetq),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .rd        (rd),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .full      (full),
    .count     (count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte as buart would and hold valid until acked, then one more cycle.
  task automatic push_byte(input logic [7:0] d);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("push_acked", 32'(got), 32'd1);
    tick();
    chk("ack_single_cycle", 32'(in_ack), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    chk(tag, 32'(out_data), 32'(d));
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    resetq   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd       = 1'b0;
    clr      = 1'b0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ack", 32'(in_ack), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    resetq = 1'b1;
    tick();

    // Single byte: one ack pulse, no duplicate from the masked stale valid.
    in_valid = 1'b1;
    in_data  = 8'h41;
    tick();
    chk("b41_ack", 32'(in_ack), 32'd1);
    chk("b41_count", 32'(count), 32'd1);
    chk("b41_out_valid", 32'(out_valid), 32'd1);
    chk("b41_out_data", 32'(out_data), 32'h41);
    tick();
    chk("b41_ack_low", 32'(in_ack), 32'd0);
    chk("b41_no_dup", 32'(count), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("b41_still_one", 32'(count), 32'd1);
    pop_expect("b41_pop", 8'h41);
    chk("b41_empty", 32'(count), 32'd0);
    chk("b41_empty_data", 32'(out_data), 32'd0);

    // Fill to 16 then drain in order; pointers wrap past 15.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) pop_expect("drain_order", 8'(8'h10 + i));
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_data", 32'(out_data), 32'd0);
    chk("drain_full", 32'(full), 32'd0);

    // Full FIFO: push and pop in the same edge.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    in_valid = 1'b1;
    in_data  = 8'h55;
    rd       = 1'b1;
    tick();
    rd = 1'b0;
    chk("swap_ack", 32'(in_ack), 32'd1);
    chk("swap_count", 32'(count), 32'd16);
    chk("swap_head", 32'(out_data), 32'h21);
    tick();
    chk("swap_ack_low", 32'(in_ack), 32'd0);
    in_valid = 1'b0;
    for (int i = 1; i < 16; i++) pop_expect("swap_order", 8'(8'h20 + i));
    chk("swap_last_count", 32'(count), 32'd1);
    pop_expect("swap_last_55", 8'h55);
    chk("swap_empty", 32'(count), 32'd0);

    // Full FIFO, byte arrives with no pop.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i));
    in_valid = 1'b1;
    in_data  = 8'h99;
`ifdef UART_RX_FIFO_OVERRUN_EN
    tick();
    chk("ovr_ack", 32'(in_ack), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_head", 32'(out_data), 32'h60);
    tick();
    chk("ovr_ack_low", 32'(in_ack), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clr_flag", 32'(overrun), 32'd0);
    chk("ovr_clr_count", 32'(count), 32'd0);
    chk("ovr_clr_valid", 32'(out_valid), 32'd0);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_no_ack", 32'(in_ack), 32'd0);
      chk("bp_count", 32'(count), 32'd16);
    end
    chk("bp_overrun", 32'(overrun), 32'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("bp_ack_on_pop", 32'(in_ack), 32'd1);
    chk("bp_count_after", 32'(count), 32'd16);
    chk("bp_head", 32'(out_data), 32'h61);
    tick();
    chk("bp_ack_low", 32'(in_ack), 32'd0);
    in_valid = 1'b0;
    for (int i = 1; i < 16; i++) pop_expect("bp_order", 8'(8'h60 + i));
    pop_expect("bp_last_99", 8'h99);
    chk("bp_empty", 32'(count), 32'd0);
`endif

    // Clear beats a simultaneous push; the byte is not acked.
    push_byte(8'h01);
    push_byte(8'h02);
    in_valid = 1'b1;
    in_data  = 8'h03;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_no_ack", 32'(in_ack), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_out_data", 32'(out_data), 32'd0);
    tick();
    chk("clr_retry_ack", 32'(in_ack), 32'd1);
    chk("clr_retry_data", 32'(out_data), 32'h03);
    tick();
    in_valid = 1'b0;
    pop_expect("clr_retry_pop", 8'h03);

    // Reads on an empty FIFO are ignored.
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_rd_count", 32'(count), 32'd0);
    end
    rd = 1'b0;
    push_byte(8'h7E);
    chk("empty_rd_count1", 32'(count), 32'd1);
    pop_expect("empty_rd_7e", 8'h7E);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i));
    in_valid = 1'b1;
    in_data  = 8'hA4;
    tick();
    chk("burst_ack", 32'(in_ack), 32'd1);
    chk("burst_count", 32'(count), 32'd5);
    in_data = 8'hC3;
    #2;
    resetq = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_ack", 32'(in_ack), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_full", 32'(full), 32'd0);
    @(negedge clk);
    resetq = 1'b1;
    tick();
    chk("post_rst_ack", 32'(in_ack), 32'd1);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'hC3);
    tick();
    chk("post_rst_ack_low", 32'(in_ack), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("post_rst_once", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the `buart` receiver and the J1 I/O read mux. It drains each received byte out of `buart` with a one-cycle acknowledge pulse on the UART rd strobe and stores it in a small circular FIFO. It presents the oldest byte and status flags to the io_din mux; a CPU io@ pop frees the slot. This lets the core tolerate multi-byte bursts without polling every character time.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `WIDTH`, default 8: data width, matching buart rx_data.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `resetq`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  buart `valid`; a received byte is waiting.
- `in_data`  in  WIDTH  buart `rx_data`.
- `in_ack`  out  1  registered one-cycle pulse, driven to buart `rd`.
- `rd`  in  1  pop strobe; io_rd_ & io_addr_[12] from top.
- `clr`  in  1  clear strobe; flushes the FIFO and clears overrun.
- `out_data`  out  WIDTH  oldest byte when not empty, else 0.
- `out_valid`  out  1  FIFO not empty.
- `full`  out  1  count == 2^DEPTH_LOG2.
- `count`  out  DEPTH_LOG2+1  occupancy, 0..2^DEPTH_LOG2.
- `overrun`  out  1  sticky drop flag (see Configuration).

## Operation

- State:
  - write pointer `wptr` and read pointer `rptr`, each DEPTH_LOG2 bits; both wrap modulo depth.
  - `count`.
  - `in_ack` register.
  - `overrun` register.
  - storage array of 2^DEPTH_LOG2 × WIDTH; the storage array is not reset.
- Push request: `push_rq = in_valid & ~in_ack`. The `~in_ack` term masks the stale `valid` in the cycle after an acknowledge, while buart is still clearing it.
- Pop: `pop = rd & (count != 0)`. A `rd` on an empty FIFO is ignored: no pointer change, no underflow.
- Push accepted when `push_rq & (~full | pop)`. Simultaneous pop on a full FIFO therefore frees the slot in the same edge.
- On accepted push:
  - write `in_data` at `wptr`;
  - `wptr` += 1;
  - `in_ack` <= 1.
- On pop: `rptr` += 1.
- `count` next value is `count + push - pop`. Push and pop in the same cycle leave count unchanged.
- `in_ack` <= 0 on every edge where no push or drop occurs. It is never high two consecutive cycles.
- `out_data = out_valid ? mem[rptr] : 0`. This is a combinational read of the head. It stays stable until the pop edge.
- `clr`:
  - pointers and count go to 0;
  - `overrun` goes to 0;
  - `in_ack` is unaffected.
  - `clr` has priority over push and pop in the same cycle; the push is lost and is not acked.
- Reset (resetq low, asynchronous): wptr=0, rptr=0, count=0, in_ack=0, overrun=0. Hence out_valid=0, full=0, out_data=0. A byte pending in buart at reset release is pushed on the first qualifying edge.

## Timing

- `in_valid` high at edge N (with in_ack=0, not full):
  - byte written at edge N;
  - count, out_valid and out_data are updated after edge N;
  - `in_ack` is high for the cycle N→N+1.
- buart sees rd at edge N+1; its valid is low by N+2. No second push occurs at N+1 because of the mask.
- Sustained throughput is one byte per 2 cycles, far above UART rate.
- Pop latency: `rd` at edge M advances the head; the new out_data is visible after M. This is consistent with top's registered io_din path (io_rd_ and io_addr_ already delayed one cycle).
- All outputs are registered or derived combinationally from registers only. There is no combinational path from `rd`/`in_valid` to any output.

## Configuration

- `UART_RX_FIFO_OVERRUN_EN` defined: when `push_rq` occurs while full and there is no pop:
  - the byte is acked (in_ack pulse, drained from buart) and discarded;
  - `overrun` <= 1, sticky until `clr` or reset;
  - FIFO contents are unchanged.
- Undefined (backpressure mode):
  - while full, no ack is issued and the byte stays in buart until a pop frees space;
  - buart may itself overwrite it on the next character;
  - `overrun` is tied 0.

## Test plan

- Reset, then `in_valid`=1 with `in_data`=0x41 held until in_ack:
  - exactly one in_ack pulse, the cycle after the push edge;
  - count=1, out_valid=1, out_data=0x41;
  - second byte not duplicated.
- Push 0x10..0x1F (16 bytes) → full=1, count=16. Then pop 16 times → out_data sequence 0x10..0x1F in order, with pointer wrap to 0; count=0, out_data=0.
- Full FIFO, `in_valid` with 0x55 and simultaneous `rd` → head popped, 0x55 written; count stays 16; 0x55 appears last after 15 more pops.
- Full FIFO, `in_valid`=1 with 0x99, no rd:
  - with macro: in_ack pulses, overrun=1, FIFO unchanged, `clr` → overrun=0, count=0;
  - without macro: in_ack stays 0 until one pop, then 0x99 is accepted.
- `rd` pulses on an empty FIFO → count stays 0, pointers unchanged; a subsequent push of 0x7E reads back correctly.
- Assert resetq low mid-burst (count=5, in_ack high) → all outputs 0 immediately, without waiting for clk; after release, a held in_valid byte is pushed once.
